// File: rtl/iir_pkg.sv
// Shared types, constants and helpers for the second-order IIR section.
//   sample_t : signed Q1.10 sample (11 bit)
//   coef_t   : signed Q2.10 coefficient (12 bit)
//   prod_t   : signed 23-bit product of one sample and one coefficient
//   acc_t    : signed 26-bit accumulator (headroom for five full-scale products)
//   state_t  : control FSM states
//   sat11    : round-half-up, drop fraction bits, clamp to the sample range
package iir_pkg;

  typedef logic signed [10:0] sample_t;
  typedef logic signed [11:0] coef_t;
  typedef logic signed [22:0] prod_t;
  typedef logic signed [25:0] acc_t;

  localparam int unsigned FRAC  = 10;
  localparam int unsigned NTAPS = 5;
  localparam int unsigned CntW  = 3;

  localparam sample_t SampleMax = 11'sb011_1111_1111;  // +1023
  localparam sample_t SampleMin = 11'sb100_0000_0000;  // -1024

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } state_t;

  // Add half an LSB of the output, arithmetic shift (ties go toward +inf), then clamp.
  function automatic sample_t sat11(input acc_t a);
    acc_t r;
    r = (a + acc_t'(1 << (FRAC - 1))) >>> FRAC;
    if (r > acc_t'(SampleMax)) begin
      return SampleMax;
    end else if (r < acc_t'(SampleMin)) begin
      return SampleMin;
    end else begin
      return sample_t'(r);
    end
  endfunction

endpackage

// File: rtl/iir_mac.sv
// Shared multiply-accumulate datapath for the IIR section.
// One multiplier is time-shared over the five taps; cnt selects the operand pair.
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the accumulator (start of a new sample)
//   en       : add the selected term into the accumulator
//   cnt      : tap index 0..4 -> b0*x0, b1*x1, b2*x2, -a1*y1, -a2*y2
//   x0..y2   : current sample and delay-line contents
//   acc      : accumulator value
module iir_mac
  import iir_pkg::*;
#(
  parameter coef_t B0 = 12'sd256,
  parameter coef_t B1 = 12'sd512,
  parameter coef_t B2 = 12'sd256,
  parameter coef_t A1 = -12'sd512,
  parameter coef_t A2 = 12'sd128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            en,
  input  logic [CntW-1:0] cnt,
  input  sample_t         x0,
  input  sample_t         x1,
  input  sample_t         x2,
  input  sample_t         y1,
  input  sample_t         y2,
  output acc_t            acc
);

  sample_t op_s;
  coef_t   op_c;
  logic    neg;
  prod_t   prod;
  prod_t   term;
  acc_t    acc_d, acc_q;

  // Operand select: feedback taps negate the product, not the coefficient, so that
  // a coefficient of -2048 never needs to be represented as +2048.
  always_comb begin
    op_s = '0;
    op_c = '0;
    neg  = 1'b0;
    case (cnt)
      3'd0: begin op_s = x0; op_c = B0; end
      3'd1: begin op_s = x1; op_c = B1; end
      3'd2: begin op_s = x2; op_c = B2; end
      3'd3: begin op_s = y1; op_c = A1; neg = 1'b1; end
      3'd4: begin op_s = y2; op_c = A2; neg = 1'b1; end
      default: begin
        op_s = '0;
        op_c = '0;
        neg  = 1'b0;
      end
    endcase
  end

  // |product| <= 2^21, so negation cannot overflow the 23-bit product.
  always_comb begin
    prod = prod_t'(op_s) * prod_t'(op_c);
    term = neg ? -prod : prod;
  end

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + acc_t'(term);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/iir_section2_mc.sv
// Second-order direct-form-I IIR section, multi-cycle: one shared multiplier, five
// MAC cycles per sample, seven cycles per sample in total (IDLE, 5x MAC, OUT).
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset; clears state, delay lines and drop
//   x        : input sample, signed Q1.10
//   x_valid  : x is offered this cycle
//   in_ready : x is accepted this cycle (IDLE and not in reset)
//   y        : output sample, signed Q1.10, held between results
//   y_valid  : one-cycle pulse when y is updated
//   drop     : sticky, set when x_valid arrives while in_ready is low
module iir_section2_mc
  import iir_pkg::*;
#(
  parameter coef_t B0 = 12'sd256,
  parameter coef_t B1 = 12'sd512,
  parameter coef_t B2 = 12'sd256,
  parameter coef_t A1 = -12'sd512,
  parameter coef_t A2 = 12'sd128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x,
  input  logic        x_valid,
  output logic        in_ready,
  output logic [10:0] y,
  output logic        y_valid,
  output logic        drop
);

  state_t          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  sample_t         x0_d, x0_q;
  sample_t         x1_d, x1_q;
  sample_t         x2_d, x2_q;
  sample_t         y1_d, y1_q;
  sample_t         y2_d, y2_q;
  sample_t         y_d, y_q;
  logic            y_valid_d, y_valid_q;
  logic            drop_d, drop_q;

  logic    accept;
  logic    mac_clear;
  logic    mac_en;
  acc_t    acc;
  sample_t yr;

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StMac;
      StMac:  if (cnt_q == CntW'(NTAPS - 1)) state_d = StOut;
      StOut:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs decoded from the current state
  always_comb begin
    in_ready  = (state_q == StIdle) && !rst;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    unique case (state_q)
      StIdle: mac_clear = 1'b1;
      StMac:  mac_en    = 1'b1;
      StOut:  ;
      default: ;
    endcase
  end

  assign accept = x_valid && in_ready;
  assign yr     = sat11(acc);

  // Datapath next-state: counter, sample/delay registers, output, drop flag
  always_comb begin
    cnt_d     = cnt_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    drop_d    = drop_q || (x_valid && !in_ready);
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x0_d  = sample_t'(x);
          cnt_d = '0;
        end
      end
      StMac: begin
        cnt_d = (cnt_q == CntW'(NTAPS - 1)) ? '0 : cnt_q + 1'b1;
      end
      StOut: begin
        // Feedback uses the saturated value so a clipped output never wraps.
        y_d       = yr;
        y_valid_d = 1'b1;
        x2_d      = x1_q;
        x1_d      = x0_q;
        y2_d      = y1_q;
        y1_d      = yr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      drop_q    <= drop_d;
    end
  end

  iir_mac #(
    .B0 (B0),
    .B1 (B1),
    .B2 (B2),
    .A1 (A1),
    .A2 (A2)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (mac_clear),
    .en    (mac_en),
    .cnt   (cnt_q),
    .x0    (x0_q),
    .x1    (x1_q),
    .x2    (x2_q),
    .y1    (y1_q),
    .y2    (y2_q),
    .acc   (acc)
  );

  assign y       = y_q;
  // A pulse landing in a reset cycle is suppressed; the result is being discarded.
  assign y_valid = y_valid_q && !rst;
  assign drop    = drop_q;

endmodule
